// File: rtl/or1200_vlx_store_ctrl_if.sv
// or1200_vlx_store_ctrl_if: byte-in, CPU stall, SPR and byte-write memory signals of the VLX store sequencer
interface or1200_vlx_store_ctrl_if;
  logic        vlx_req_i;
  logic        drain_i;
  logic        byte_valid_i;
  logic [7:0]  byte_dat_i;
  logic        byte_ready_o;
  logic        stall_o;
  logic        spr_we_i;
  logic        spr_sel_i;
  logic [31:0] spr_dat_i;
  logic [31:0] spr_dat_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic [7:0]  mem_dat_o;
  logic        mem_ack_i;
  modport slave (
    input  vlx_req_i, drain_i, byte_valid_i, byte_dat_i, spr_we_i, spr_sel_i, spr_dat_i, mem_ack_i,
    output byte_ready_o, stall_o, spr_dat_o, mem_req_o, mem_addr_o, mem_dat_o
  );
  modport master (
    output vlx_req_i, drain_i, byte_valid_i, byte_dat_i, spr_we_i, spr_sel_i, spr_dat_i, mem_ack_i,
    input  byte_ready_o, stall_o, spr_dat_o, mem_req_o, mem_addr_o, mem_dat_o
  );
endinterface

// File: rtl/or1200_vlx_store_ctrl.sv
// or1200_vlx_store_ctrl: byte FIFO plus store FSM writing VLX output bytes to memory with 0xFF/0x00 stuffing
module or1200_vlx_store_ctrl #(
  parameter int DEPTH = 4
) (
  input logic clk_i,
  input logic rst_i,
  or1200_vlx_store_ctrl_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [1:0] IDLE = 2'd0, WRITE = 2'd1, STUFF = 2'd2;
  logic [7:0]    fifo_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] count_q, count_d;
  logic [1:0]    state_q, state_d;
  logic [31:0]   ptr_q, ptr_d, bcnt_q, bcnt_d;
  logic [7:0]    head;
  logic          push, pop, ack;
  assign head = fifo_q[rd_q];
  assign push = bus.byte_valid_i & bus.byte_ready_o;
  assign ack = (state_q != IDLE) & bus.mem_ack_i;
  assign pop = (state_q == WRITE) & bus.mem_ack_i;
  assign count_d = count_q + CW'(push) - CW'(pop);
  assign bus.byte_ready_o = count_q != CW'(DEPTH);
  assign bus.mem_req_o = state_q != IDLE;
  assign bus.mem_addr_o = ptr_q;
  assign bus.mem_dat_o = (state_q == STUFF) ? 8'h00 : head;
  assign bus.spr_dat_o = bus.spr_sel_i ? bcnt_q : ptr_q;
  assign bus.stall_o = (bus.vlx_req_i & (count_q > CW'(DEPTH - 2))) |
                       (bus.drain_i & ((state_q != IDLE) | (count_q != '0)));
  // next state: an acked 0xFF is always followed by a stuffed 0x00 before the next FIFO byte
  always_comb begin
    state_d = state_q;
    if (state_q == IDLE) state_d = (count_q != '0) ? WRITE : IDLE;
    else if (ack) state_d = (state_q == WRITE && head == 8'hFF) ? STUFF : (count_d != '0) ? WRITE : IDLE;
  end
  // SPR writes take priority over the ack increment; a pointer write also clears the byte count
  always_comb begin
    ptr_d = (bus.spr_we_i & ~bus.spr_sel_i) ? bus.spr_dat_i : ptr_q + 32'(ack);
    bcnt_d = bus.spr_we_i ? (bus.spr_sel_i ? bus.spr_dat_i : 32'h0) : bcnt_q + 32'(ack);
  end
  // control state, FIFO pointers and SPR registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      count_q <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      ptr_q   <= '0;
      bcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      wr_q    <= push ? wr_q + AW'(1) : wr_q;
      rd_q    <= pop ? rd_q + AW'(1) : rd_q;
      ptr_q   <= ptr_d;
      bcnt_q  <= bcnt_d;
    end
  end
  // FIFO storage is cleared so the idle head (and mem_dat_o) reads 0x00 out of reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) fifo_q <= '{default: '0};
    else if (push) fifo_q[wr_q] <= bus.byte_dat_i;
  end
endmodule

// File: tb/tb_or1200_vlx_store_ctrl.sv
// tb_or1200_vlx_store_ctrl: vector table plus write scoreboard for the VLX store sequencer
module tb_or1200_vlx_store_ctrl;
  logic clk = 0;
  logic rst = 1;
  int checks = 0;
  int errors = 0;
  int ack_mode = 0;
  logic [31:0] mptr = 0;
  logic [39:0] sb [$];
  typedef struct {
    logic [7:0]  dat;
    logic [31:0] ptr;
    logic [31:0] bcnt;
  } vec_t;
  vec_t vecs [6];
  or1200_vlx_store_ctrl_if bus();
  or1200_vlx_store_ctrl #(.DEPTH(4)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic push_byte(input logic [7:0] d, input bit enq);
    bus.byte_valid_i = 1;
    bus.byte_dat_i = d;
    @(posedge clk);
    #1 bus.byte_valid_i = 0;
    if (enq) begin
      sb.push_back({mptr, d});
      mptr++;
      if (d == 8'hFF) begin
        sb.push_back({mptr, 8'h00});
        mptr++;
      end
    end
  endtask
  task automatic spr_write(input logic sel, input logic [31:0] d);
    bus.spr_we_i = 1;
    bus.spr_sel_i = sel;
    bus.spr_dat_i = d;
    @(posedge clk);
    #1 bus.spr_we_i = 0;
    if (!sel) mptr = d;
  endtask
  task automatic spr_chk(input string name, input logic sel, input logic [31:0] exp);
    bus.spr_sel_i = sel;
    #1 chk(name, bus.spr_dat_o, exp);
  endtask
  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !bus.mem_req_o) ok = 1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: timeout, %0d writes still expected", sb.size());
    end
    @(posedge clk);
    #1;
  endtask
  // ack generator: 0 low, 1 high, 2 toggling, 3 left to the test
  initial forever begin
    @(posedge clk);
    #1;
    if (ack_mode == 0) bus.mem_ack_i = 0;
    else if (ack_mode == 1) bus.mem_ack_i = 1;
    else if (ack_mode == 2) bus.mem_ack_i = ~bus.mem_ack_i;
  end
  // scoreboard: every accepted write must match the next expected {addr, data}
  initial forever begin
    @(negedge clk);
    if (!rst && bus.mem_req_o && bus.mem_ack_i) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL write: unexpected %02h @%08h", bus.mem_dat_o, bus.mem_addr_o);
      end else chk("write", {bus.mem_addr_o, bus.mem_dat_o}, sb.pop_front());
    end
  end
  initial begin
    int acks;
    bit done;
    vecs[0] = '{8'h12, 32'h1001, 32'd1};
    vecs[1] = '{8'hFF, 32'h1003, 32'd3};
    vecs[2] = '{8'h00, 32'h1004, 32'd4};
    vecs[3] = '{8'hFE, 32'h1005, 32'd5};
    vecs[4] = '{8'hFF, 32'h1007, 32'd7};
    vecs[5] = '{8'h7F, 32'h1008, 32'd8};
    bus.vlx_req_i = 0; bus.drain_i = 0; bus.byte_valid_i = 0; bus.byte_dat_i = 0;
    bus.spr_we_i = 0; bus.spr_sel_i = 0; bus.spr_dat_i = 0; bus.mem_ack_i = 0;
    #1;
    chk("rst_req", bus.mem_req_o, 0);
    chk("rst_ready", bus.byte_ready_o, 1);
    chk("rst_dat", bus.mem_dat_o, 8'h00);
    chk("rst_stall", bus.stall_o, 0);
    spr_chk("rst_ptr", 0, 0);
    spr_chk("rst_bcnt", 1, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 0;
    @(posedge clk);
    #1;
    spr_write(0, 32'h1000);
    ack_mode = 1;
    for (int i = 0; i < 6; i++) begin
      push_byte(vecs[i].dat, 1);
      if (i == 0) begin
        @(negedge clk) chk("lat_req_lo", bus.mem_req_o, 0);
        @(negedge clk) chk("lat_req_hi", {bus.mem_req_o, bus.mem_addr_o}, {1'b1, 32'h1000});
      end
      wait_idle();
      spr_chk($sformatf("vec%0d_ptr", i), 0, vecs[i].ptr);
      spr_chk($sformatf("vec%0d_bcnt", i), 1, vecs[i].bcnt);
    end
    spr_write(0, 32'h1000);
    push_byte(8'hFF, 1);
    push_byte(8'h34, 1);
    repeat (3) @(negedge clk);
    chk("ff_back_to_back", sb.size(), 0);
    wait_idle();
    spr_chk("ff_bcnt", 1, 3);
    ack_mode = 0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      push_byte(8'hA1 + 8'(i), 1);
      bus.vlx_req_i = 1;
      #1 chk($sformatf("full_stall%0d", i), bus.stall_o, i >= 2);
      chk($sformatf("full_ready%0d", i), bus.byte_ready_o, i < 3);
      bus.vlx_req_i = 0;
    end
    push_byte(8'hEE, 0);
    chk("full_still_ready0", bus.byte_ready_o, 0);
    ack_mode = 1;
    wait_idle();
    chk("full_ready_back", bus.byte_ready_o, 1);
    ack_mode = 0;
    @(posedge clk);
    #1;
    push_byte(8'h55, 1);
    push_byte(8'h66, 1);
    bus.drain_i = 1;
    ack_mode = 2;
    acks = 0;
    done = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      chk("drain_stall", bus.stall_o, !done);
      if (done) break;
      if (bus.mem_req_o && bus.mem_ack_i) acks++;
      if (acks == 2) done = 1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL drain: timeout after %0d acks", acks);
    end
    bus.drain_i = 0;
    ack_mode = 1;
    wait_idle();
    ack_mode = 0;
    @(posedge clk);
    #1;
    spr_write(0, 32'h1005);
    push_byte(8'h42, 0);
    push_byte(8'h43, 0);
    sb.push_back({32'h1005, 8'h42});
    sb.push_back({32'h2000, 8'h43});
    ack_mode = 3;
    bus.mem_ack_i = 1;
    bus.spr_we_i = 1;
    bus.spr_sel_i = 0;
    bus.spr_dat_i = 32'h2000;
    @(posedge clk);
    #1 bus.mem_ack_i = 0;
    bus.spr_we_i = 0;
    spr_chk("sprwin_ptr", 0, 32'h2000);
    spr_chk("sprwin_bcnt", 1, 0);
    ack_mode = 1;
    wait_idle();
    spr_chk("sprwin_ptr2", 0, 32'h2001);
    spr_chk("sprwin_bcnt2", 1, 1);
    ack_mode = 0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) push_byte(8'hC0 + 8'(i), 0);
    @(negedge clk);
    chk("pre_rst_req", bus.mem_req_o, 1);
    rst = 1;
    #1;
    chk("async_rst_req", bus.mem_req_o, 0);
    chk("async_rst_dat", bus.mem_dat_o, 8'h00);
    chk("async_rst_ready", bus.byte_ready_o, 1);
    @(posedge clk);
    @(negedge clk) rst = 0;
    mptr = 0;
    @(posedge clk);
    #1;
    spr_chk("post_rst_ptr", 0, 0);
    spr_chk("post_rst_bcnt", 1, 0);
    ack_mode = 1;
    repeat (6) @(negedge clk);
    chk("post_rst_idle", bus.mem_req_o, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
